// File: rtl/axi_txn_arbiter.sv
// Round-robin arbiter sharing one burst Master between two requesters.
// Issues one read/write command at a time and reports completion or timeout to the winner.
`timescale 1ns/1ps
module axi_txn_arbiter #(
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned TO_W        = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [7:0]        req0_addr,
  input  logic [3:0]        req0_len,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic [4:0]        req0_resp,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [7:0]        req1_addr,
  input  logic [3:0]        req1_len,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic [4:0]        req1_resp,
  output logic              en,
  output logic              en_,
  output logic [15:0]       tb_R,
  output logic [15:0]       tb_W,
  output logic [DATA_W-1:0] INDATA,
  input  logic              RVALID,
  input  logic              RREADY,
  input  logic              RLAST,
  input  logic              RRESP,
  input  logic              BVALID,
  input  logic              BREADY,
  input  logic [4:0]        BRESP,
  output logic              busy
);

  localparam logic [TO_W:0] TO_LIMIT = (TO_W + 1)'(TIMEOUT_CYC);
  localparam logic [4:0]    RESP_TO  = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD,
    S_WAIT_WR,
    S_DONE
  } state_t;

  state_t            state, next_state;
  logic              armed;
  logic              rr;
  logic              lat_write;
  logic              winner;
  logic [TO_W-1:0]   cnt, cnt_next;
  logic [TO_W:0]     cnt_inc;
  logic              grant;
  logic              sel_id;
  logic              sel_write;
  logic [7:0]        sel_addr;
  logic [3:0]        sel_len;
  logic [DATA_W-1:0] sel_wdata;
  logic [15:0]       sel_cmd;
  logic [4:0]        resp_next;

  // Requester selection: rr breaks the tie only when both are valid
  always_comb begin
    sel_id    = req0_valid ? (req1_valid ? rr : 1'b0) : 1'b1;
    sel_write = sel_id ? req1_write : req0_write;
    sel_addr  = sel_id ? req1_addr  : req0_addr;
    sel_len   = sel_id ? req1_len   : req0_len;
    sel_wdata = sel_id ? req1_wdata : req0_wdata;
    sel_cmd   = {sel_addr, sel_len, 3'b000, sel_id};
  end

  // Next-state, grant handshake and completion detection
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    cnt_next   = cnt;
    resp_next  = 5'b00000;
    cnt_inc    = {1'b0, cnt} + (TO_W + 1)'(1);
    unique case (state)
      S_IDLE: begin
        if (armed && (req0_valid || req1_valid)) begin
          grant      = 1'b1;
          req0_ready = ~sel_id;
          req1_ready = sel_id;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_next   = '0;
        next_state = lat_write ? S_WAIT_WR : S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (RVALID && RREADY && RLAST) begin
          resp_next  = {4'b0000, RRESP};
          next_state = S_DONE;
        end else if (cnt_inc >= TO_LIMIT) begin
          resp_next  = RESP_TO;
          next_state = S_DONE;
        end else begin
          cnt_next = cnt_inc[TO_W-1:0];
        end
      end
      S_WAIT_WR: begin
        if (BVALID && BREADY) begin
          resp_next  = BRESP;
          next_state = S_DONE;
        end else if (cnt_inc >= TO_LIMIT) begin
          resp_next  = RESP_TO;
          next_state = S_DONE;
        end else begin
          cnt_next = cnt_inc[TO_W-1:0];
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State register; armed keeps ready low until the first cycle after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      rr        <= 1'b0;
      lat_write <= 1'b0;
      winner    <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
      cnt   <= cnt_next;
      if (grant) begin
        lat_write <= sel_write;
        winner    <= sel_id;
        rr        <= ~sel_id;
      end
    end
  end

  // Registered Master command and requester completion outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en        <= 1'b0;
      en_       <= 1'b0;
      tb_R      <= '0;
      tb_W      <= '0;
      INDATA    <= '0;
      busy      <= 1'b0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      req0_resp <= '0;
      req1_resp <= '0;
    end else begin
      en        <= grant & ~sel_write;
      en_       <= grant & sel_write;
      busy      <= (next_state != S_IDLE);
      req0_done <= (next_state == S_DONE) && !winner;
      req1_done <= (next_state == S_DONE) && winner;
      req0_resp <= ((next_state == S_DONE) && !winner) ? resp_next : 5'b00000;
      req1_resp <= ((next_state == S_DONE) && winner)  ? resp_next : 5'b00000;
      if (grant) begin
        tb_R   <= sel_write ? 16'h0000 : sel_cmd;
        tb_W   <= sel_write ? sel_cmd : 16'h0000;
        INDATA <= sel_write ? sel_wdata : '0;
      end else if (next_state == S_IDLE) begin
        tb_R   <= '0;
        tb_W   <= '0;
        INDATA <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axi_txn_arbiter.sv
// Scoreboard bench for axi_txn_arbiter: stimulus queues expected commands/completions,
// a negedge monitor pops and compares them as the DUT presents en/en_ and done pulses.
`timescale 1ns/1ps
module tb_axi_txn_arbiter;
  localparam int unsigned DATA_W      = 128;
  localparam int unsigned TIMEOUT_CYC = 1023;
  localparam int unsigned TO_W        = 10;

  logic clk, rst;
  logic req0_valid, req0_ready, req0_write, req0_done;
  logic req1_valid, req1_ready, req1_write, req1_done;
  logic [7:0] req0_addr, req1_addr;
  logic [3:0] req0_len, req1_len;
  logic [DATA_W-1:0] req0_wdata, req1_wdata, INDATA;
  logic [4:0] req0_resp, req1_resp, BRESP;
  logic en, en_, busy;
  logic [15:0] tb_R, tb_W;
  logic RVALID, RREADY, RLAST, RRESP, BVALID, BREADY;

  axi_txn_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_len(req0_len), .req0_wdata(req0_wdata),
    .req0_done(req0_done), .req0_resp(req0_resp),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_len(req1_len), .req1_wdata(req1_wdata),
    .req1_done(req1_done), .req1_resp(req1_resp),
    .en(en), .en_(en_), .tb_R(tb_R), .tb_W(tb_W), .INDATA(INDATA),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RRESP(RRESP),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .busy(busy)
  );

  typedef struct { logic write; logic [15:0] cmd; logic [DATA_W-1:0] data; } cmd_t;
  typedef struct { int n; logic [4:0] resp; } done_t;

  cmd_t  exp_cmd_q[$];
  done_t exp_done_q[$];
  int    exp_cyc_q[$];
  int    acc_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int slave_mode = 0;   // 0 normal, 1 never respond (timeout), 2 silent, 3 respond on last legal cycle
  logic [4:0] slave_resp = 5'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event occurred, required none", name);
  endfunction

  function automatic void push_cmd(logic wr, logic [15:0] c, logic [DATA_W-1:0] d);
    cmd_t e;
    e.write = wr; e.cmd = c; e.data = d;
    exp_cmd_q.push_back(e);
  endfunction

  function automatic void push_done(int n, logic [4:0] r);
    done_t d;
    d.n = n; d.resp = r;
    exp_done_q.push_back(d);
  endfunction

  // Monitor: handshake sanity, command pulses and completion pulses
  always @(negedge clk) begin
    if (rst) begin
      if (req0_ready && req1_ready) fail("dual_ready");
      if (req0_ready && (!req0_valid || busy)) fail("ready0_spurious");
      if (req1_ready && (!req1_valid || busy)) fail("ready1_spurious");
      if (en || en_) begin
        if (en && en_) fail("en_both");
        if (exp_cmd_q.size() == 0) fail("unexpected_cmd");
        else begin
          cmd_t e;
          e = exp_cmd_q.pop_front();
          check("cmd_kind", 128'(en_), 128'(e.write));
          check("cmd_bus", 128'(en_ ? tb_W : tb_R), 128'(e.cmd));
          check("cmd_other_bus", 128'(en_ ? tb_R : tb_W), 128'(0));
          if (e.write) check("indata", 128'(INDATA), 128'(e.data));
        end
        if (acc_q.size() == 0) fail("issue_without_accept");
        else check("issue_latency", 128'(cyc), 128'(acc_q.pop_front() + 1));
      end
      if (req0_done || req1_done) begin
        if (req0_done && req1_done) fail("done_both");
        if (exp_done_q.size() == 0) fail("unexpected_done");
        else begin
          done_t d;
          d = exp_done_q.pop_front();
          check("done_id", 128'(req1_done), 128'(d.n));
          check("done_resp", 128'(req1_done ? req1_resp : req0_resp), 128'(d.resp));
        end
        if (exp_cyc_q.size() == 0) fail("done_without_completion");
        else check("done_cycle", 128'(cyc), 128'(exp_cyc_q.pop_front()));
      end
    end
  end

  // Slave model: answers each Master command according to slave_mode
  initial begin
    RVALID = 0; RREADY = 0; RLAST = 0; RRESP = 0; BVALID = 0; BREADY = 0; BRESP = '0;
    forever begin
      @(negedge clk);
      if (rst && (en || en_)) begin
        int issue_cyc;
        logic wr;
        issue_cyc = cyc;
        wr = en_;
        if (slave_mode == 1) exp_cyc_q.push_back(issue_cyc + 1 + int'(TIMEOUT_CYC));
        else if (slave_mode == 3) begin
          repeat (TIMEOUT_CYC) @(posedge clk);
          #1 BVALID = 1; BREADY = 1; BRESP = slave_resp;
          exp_cyc_q.push_back(cyc + 1);
          @(posedge clk); #1 BVALID = 0; BREADY = 0; BRESP = '0;
        end else if (slave_mode == 0 && wr) begin
          repeat (3) @(posedge clk);
          #1 BVALID = 1; BREADY = 0; BRESP = 5'h1F;
          @(posedge clk); #1 BREADY = 1; BRESP = slave_resp;
          exp_cyc_q.push_back(cyc + 1);
          @(posedge clk); #1 BVALID = 0; BREADY = 0; BRESP = '0;
        end else if (slave_mode == 0) begin
          for (int b = 0; b < 16; b++) begin
            if (b == 15) begin
              @(posedge clk); #1 RVALID = 1; RREADY = 0; RLAST = 1; RRESP = ~slave_resp[0];
              @(posedge clk); #1 RVALID = 0; RREADY = 1; RLAST = 1;
            end
            @(posedge clk);
            #1 RVALID = 1; RREADY = 1; RLAST = (b == 15); RRESP = slave_resp[0];
          end
          exp_cyc_q.push_back(cyc + 1);
          @(posedge clk); #1 RVALID = 0; RREADY = 0; RLAST = 0; RRESP = 0;
        end
      end
    end
  end

  task automatic drive_req(input int n, input logic wr, input logic [7:0] addr,
                           input logic [3:0] len, input logic [DATA_W-1:0] wd);
    bit got;
    got = 0;
    @(posedge clk); #1;
    if (n == 0) begin
      req0_valid = 1; req0_write = wr; req0_addr = addr; req0_len = len; req0_wdata = wd;
    end else begin
      req1_valid = 1; req1_write = wr; req1_addr = addr; req1_len = len; req1_wdata = wd;
    end
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if ((n == 0) ? req0_ready : req1_ready) begin
        got = 1;
        acc_q.push_back(cyc);
      end
    end
    if (!got) fail("grant_timeout");
    @(posedge clk); #1;
    if (n == 0) req0_valid = 0;
    else req1_valid = 0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy && exp_done_q.size() == 0 && exp_cmd_q.size() == 0) ok = 1;
    end
    if (!ok) fail("idle_timeout");
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, 128'({req0_ready, req1_ready, req0_done, req1_done, en, en_, busy}), 128'(0));
    check({tag, "_resp"}, 128'({req0_resp, req1_resp}), 128'(0));
    check({tag, "_cmd"}, 128'({tb_R, tb_W}), 128'(0));
    check({tag, "_indata"}, 128'(INDATA), 128'(0));
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
  endtask

  initial begin
    logic [DATA_W-1:0] pat;
    pat = DATA_W'({4{32'h01020304}});
    rst = 0;
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_len = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_len = '0; req1_wdata = '0;

    // 1: reset state, a valid request held during reset must not be accepted
    #2 req0_valid = 1; req0_write = 1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    req0_valid = 0; req0_write = 0;
    rst = 1;
    repeat (4) @(negedge clk);
    check("post_reset_idle", 128'({en, en_, busy}), 128'(0));

    // 2: req0 write; req1 blips valid while busy and must be ignored
    slave_mode = 0; slave_resp = 5'h00;
    push_cmd(1, 16'h01F0, pat);
    push_done(0, 5'h00);
    drive_req(0, 1, 8'h01, 4'hF, pat);
    req1_valid = 1; req1_write = 1; req1_addr = 8'hEE; req1_len = 4'h1; req1_wdata = '1;
    repeat (2) @(posedge clk);
    #1 req1_valid = 0;
    wait_idle(200);
    repeat (3) @(negedge clk);

    // 3: idle channel activity ignored, then req1 read with non-last beats
    @(posedge clk); #1 BVALID = 1; BREADY = 1; RVALID = 1; RREADY = 1; RLAST = 1;
    @(posedge clk); #1 BVALID = 0; BREADY = 0; RVALID = 0; RREADY = 0; RLAST = 0;
    repeat (3) @(negedge clk);
    slave_resp = 5'h01;
    push_cmd(0, 16'h01F1, '0);
    push_done(1, 5'h01);
    drive_req(1, 0, 8'h01, 4'hF, '0);
    wait_idle(200);

    // 4: simultaneous requests from reset, then continuous contention alternates
    pulse_reset();
    slave_resp = 5'h0B;
    push_cmd(0, 16'h1030, '0);              push_done(0, 5'h01);
    push_cmd(1, 16'h2011, DATA_W'(128'hA5)); push_done(1, 5'h0B);
    fork
      drive_req(0, 0, 8'h10, 4'h3, '0);
      drive_req(1, 1, 8'h20, 4'h1, DATA_W'(128'hA5));
    join
    wait_idle(300);
    push_cmd(1, 16'h3020, pat);             push_done(0, 5'h0B);
    push_cmd(0, 16'h3141, '0);              push_done(1, 5'h01);
    push_cmd(0, 16'h3250, '0);              push_done(0, 5'h01);
    push_cmd(1, 16'h3361, ~pat);            push_done(1, 5'h0B);
    fork
      begin
        drive_req(0, 1, 8'h30, 4'h2, pat);
        drive_req(0, 0, 8'h32, 4'h5, '0);
      end
      begin
        drive_req(1, 0, 8'h31, 4'h4, '0);
        drive_req(1, 1, 8'h33, 4'h6, ~pat);
      end
    join
    wait_idle(400);

    // 5: timeout, completion on the limit cycle, then a normal burst
    slave_mode = 1;
    push_cmd(1, 16'h4070, pat);
    push_done(0, 5'h1F);
    drive_req(0, 1, 8'h40, 4'h7, pat);
    wait_idle(3000);
    slave_mode = 3; slave_resp = 5'h05;
    push_cmd(1, 16'h4121, ~pat);
    push_done(1, 5'h05);
    drive_req(1, 1, 8'h41, 4'h2, ~pat);
    wait_idle(3000);
    slave_mode = 0; slave_resp = 5'h00;
    push_cmd(0, 16'h80F0, '0);
    push_done(0, 5'h00);
    drive_req(0, 0, 8'h80, 4'hF, '0);
    wait_idle(200);

    // 6: reset during a read wait abandons it; rr returns to req0
    slave_mode = 2;
    push_cmd(0, 16'h2230, '0);
    drive_req(0, 0, 8'h22, 4'h3, '0);
    repeat (4) @(negedge clk);
    RVALID = 1; RREADY = 1;
    #2 rst = 0;
    #1 check_outputs_zero("midburst_reset");
    RVALID = 0; RREADY = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    slave_mode = 0;
    push_cmd(1, 16'h5010, pat);  push_done(0, 5'h00);
    push_cmd(1, 16'h5111, ~pat); push_done(1, 5'h00);
    fork
      drive_req(0, 1, 8'h50, 4'h1, pat);
      drive_req(1, 1, 8'h51, 4'h1, ~pat);
    join
    wait_idle(300);

    repeat (5) @(negedge clk);
    check("leftover_cmd", 128'(exp_cmd_q.size()), 128'(0));
    check("leftover_done", 128'(exp_done_q.size()), 128'(0));
    check("leftover_cyc", 128'(exp_cyc_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
